// File: rtl/fft_power_pkg.sv
// Shared types and width helpers for the FFT power averager.
// Widths are derived from the top-level parameters through the helper functions.
package fft_power_pkg;

  localparam int DEF_IWIDTH  = 19;
  localparam int DEF_LGWIDTH = 12;
  localparam int DEF_LGAVG   = 2;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  // Width of re*re and of re^2+im^2 (the sum cannot exceed 2^(2*iw-1)).
  function automatic int prod_width(input int iw);
    return 2 * iw;
  endfunction

  // Per-bin running sum over 2^lgavg frames.
  function automatic int acc_width(input int iw, input int lgavg);
    return 2 * iw + lgavg;
  endfunction

endpackage

// File: rtl/fft_power_ram.sv
// Simple dual-port accumulator RAM: one write port, one registered read port.
// Both ports only act when ce is high; contents are never reset.
module fft_power_ram #(
  parameter int AW = 12,
  parameter int DW = 40
) (
  input  logic          clk,
  input  logic          ce,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (ce) begin
      if (wr_en) begin
        mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fft_power_avg.sv
// Per-bin power (re^2+im^2) of a bit-reversed FFT stream, averaged over
// 2^LGAVG frames; one averaged spectrum is emitted during the last frame of each group.
module fft_power_avg
  import fft_power_pkg::*;
#(
  parameter int IWIDTH  = DEF_IWIDTH,
  parameter int LGWIDTH = DEF_LGWIDTH,
  parameter int LGAVG   = DEF_LGAVG,
  parameter int PWIDTH  = 2 * IWIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clk_enable,
  input  logic [2*IWIDTH-1:0]   i_result,
  input  logic                  i_sync,
  output logic                  o_valid,
  output logic [PWIDTH-1:0]     o_power,
  output logic [LGWIDTH-1:0]    o_bin,
  output logic                  o_sync,
  output logic                  o_resync
);

  localparam int PW2  = prod_width(IWIDTH);
  localparam int AWID = acc_width(IWIDTH, LGAVG);
  localparam int FW   = (LGAVG > 0) ? LGAVG : 1;

  localparam logic [FW-1:0]      LAST_FRAME = FW'((1 << LGAVG) - 1);
  localparam logic [LGWIDTH-1:0] LAST_BIN   = '1;

  // ---------------- frame/bin tracking FSM ----------------
  state_t               state, state_nxt;
  logic [LGWIDTH-1:0]   bin_cnt, bin_nxt, cur_bin;
  logic [FW-1:0]        frame_cnt, frame_nxt, cur_frame;
  logic                 active;
  logic                 resync;
  logic                 cur_first, cur_last;

  // cur_bin/cur_frame describe the sample on i_result this cycle; a
  // sync at a nonzero bin restarts both, discarding the partial group.
  always_comb begin
    state_nxt = state;
    active    = 1'b0;
    resync    = 1'b0;
    cur_bin   = bin_cnt;
    cur_frame = frame_cnt;
    case (state)
      IDLE: begin
        if (i_sync) begin
          state_nxt = ACCUM;
          active    = 1'b1;
          cur_bin   = '0;
          cur_frame = '0;
        end
      end
      ACCUM: begin
        active = 1'b1;
        if (i_sync && (bin_cnt != '0)) begin
          resync    = 1'b1;
          cur_bin   = '0;
          cur_frame = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    bin_nxt   = cur_bin + 1'b1;
    frame_nxt = cur_frame;
    if (cur_bin == LAST_BIN) begin
      frame_nxt = (cur_frame == LAST_FRAME) ? '0 : cur_frame + 1'b1;
    end
    cur_first = (cur_frame == '0);
    cur_last  = (cur_frame == LAST_FRAME);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      bin_cnt   <= '0;
      frame_cnt <= '0;
    end else if (i_clk_enable) begin
      state <= state_nxt;
      if (active) begin
        bin_cnt   <= bin_nxt;
        frame_cnt <= frame_nxt;
      end
    end
  end

  // ---------------- stage A: capture sample, issue RAM read ----------------
  logic signed [IWIDTH-1:0] a_re, a_im;
  logic [LGWIDTH-1:0]       a_bin;
  logic                     a_first, a_last, a_active;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      a_active <= 1'b0;
      a_re     <= '0;
      a_im     <= '0;
      a_bin    <= '0;
      a_first  <= 1'b0;
      a_last   <= 1'b0;
    end else if (i_clk_enable) begin
      a_active <= active;
      a_re     <= i_result[2*IWIDTH-1:IWIDTH];
      a_im     <= i_result[IWIDTH-1:0];
      a_bin    <= cur_bin;
      a_first  <= cur_first;
      a_last   <= cur_last;
    end
  end

  // ---------------- stage B: squares, RAM data ----------------
  logic signed [PW2-1:0] re_x, im_x;
  logic [PW2-1:0]        b_sq_re, b_sq_im;
  logic [AWID-1:0]       rd_data, b_rd;
  logic [LGWIDTH-1:0]    b_bin;
  logic                  b_first, b_last, b_active;

  always_comb begin
    re_x = PW2'(a_re);
    im_x = PW2'(a_im);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      b_active <= 1'b0;
      b_sq_re  <= '0;
      b_sq_im  <= '0;
      b_rd     <= '0;
      b_bin    <= '0;
      b_first  <= 1'b0;
      b_last   <= 1'b0;
    end else if (i_clk_enable) begin
      b_active <= a_active;
      b_sq_re  <= re_x * re_x;
      b_sq_im  <= im_x * im_x;
      b_rd     <= rd_data;
      b_bin    <= a_bin;
      b_first  <= a_first;
      b_last   <= a_last;
    end
  end

  // ---------------- stage C: accumulate, write back, output ----------------
  logic [PW2-1:0]  pwr;
  logic [AWID-1:0] acc;

  // The first frame of a group overwrites whatever the RAM held.
  always_comb begin
    pwr = b_sq_re + b_sq_im;
    acc = b_first ? AWID'(pwr) : b_rd + AWID'(pwr);
  end

  fft_power_ram #(
    .AW (LGWIDTH),
    .DW (AWID)
  ) u_ram (
    .clk     (i_clk),
    .ce      (i_clk_enable),
    .wr_en   (b_active),
    .wr_addr (b_bin),
    .wr_data (acc),
    .rd_addr (cur_bin),
    .rd_data (rd_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid  <= 1'b0;
      o_power  <= '0;
      o_bin    <= '0;
      o_sync   <= 1'b0;
      o_resync <= 1'b0;
    end else if (i_clk_enable) begin
      o_resync <= resync;
      if (b_active && b_last) begin
        o_valid <= 1'b1;
        o_power <= PWIDTH'(acc >> LGAVG);
        o_bin   <= b_bin;
        o_sync  <= (b_bin == '0);
      end else begin
        o_valid <= 1'b0;
        o_sync  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_power_avg.sv
// Directed bench for fft_power_avg with 8-bin frames averaged over 4 frames.
// Expected spectra are hand-computed constants queued before each group is driven.
module tb_fft_power_avg;

  localparam int IW  = 19;
  localparam int LGW = 3;
  localparam int LGA = 2;
  localparam int PW  = 2 * IW;
  localparam int EW  = 1 + LGW + PW;

  logic              i_clk;
  logic              i_reset;
  logic              i_clk_enable;
  logic [2*IW-1:0]   i_result;
  logic              i_sync;
  logic              o_valid;
  logic [PW-1:0]     o_power;
  logic [LGW-1:0]    o_bin;
  logic              o_sync;
  logic              o_resync;

  fft_power_avg #(
    .IWIDTH  (IW),
    .LGWIDTH (LGW),
    .LGAVG   (LGA),
    .PWIDTH  (PW)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clk_enable (i_clk_enable),
    .i_result     (i_result),
    .i_sync       (i_sync),
    .o_valid      (o_valid),
    .o_power      (o_power),
    .o_bin        (o_bin),
    .o_sync       (o_sync),
    .o_resync     (o_resync)
  );

  // ---------------- clock ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int  en_cnt     = 0;
  int  mark       = 0;
  int  first_idx  = 0;
  bit  got_first  = 0;
  int  resync_cnt = 0;
  bit  gap_mode   = 0;

  task automatic push_exp(input logic [PW-1:0] pwr, input int bin);
    exp_q.push_back({(bin == 0), LGW'(bin), pwr});
  endtask

  always @(negedge i_clk) begin
    if (i_clk_enable) begin
      if (o_resync) resync_cnt++;
      if (o_valid) begin
        if (!got_first) begin
          first_idx = en_cnt;
          got_first = 1;
        end
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {63'd0, o_valid}, 64'd0);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("power", o_power, e[PW-1:0]);
          check("bin",   o_bin,   e[PW+LGW-1:PW]);
          check("sync",  o_sync,  e[EW-1]);
        end
      end else if (o_sync) begin
        check("sync_without_valid", o_sync, 64'd0);
      end
      en_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [IW-1:0] re, input logic [IW-1:0] im, input bit sync);
    i_result     = {re, im};
    i_sync       = sync;
    i_clk_enable = 1'b1;
    @(posedge i_clk); #1;
    i_sync = 1'b0;
    if (gap_mode) begin
      i_clk_enable = 1'b0;
      @(posedge i_clk); #1;
      i_clk_enable = 1'b1;
    end
  endtask

  // mode: 0 re=3,im=4 | 1 re=bin,im=0 | 2 re=im=-2^18 | 3 re=im=1 | 4 re=7,im=0 | 5 re=1,im=2
  task automatic send_frame(input int mode, input int f);
    logic [IW-1:0] re, im;
    for (int k = 0; k < 8; k++) begin
      case (mode)
        0: begin re = 19'd3;       im = 19'd4;       end
        1: begin re = 19'(k);      im = 19'd0;       end
        2: begin re = 19'h40000;   im = 19'h40000;   end
        3: begin re = 19'd1;       im = 19'd1;       end
        4: begin re = 19'd7;       im = 19'd0;       end
        default: begin re = 19'd1; im = 19'd2;       end
      endcase
      if (f == 3 && k == 0) mark = en_cnt;
      send(re, im, k == 0);
    end
  endtask

  task automatic flush();
    for (int k = 0; k < 3; k++) send('0, '0, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    i_reset      = 1'b1;
    i_clk_enable = 1'b1;
    i_sync       = 1'b0;
    i_result     = '0;
    repeat (2) begin
      @(posedge i_clk); #1;
    end
    check({tag, "_valid"},  o_valid,  64'd0);
    check({tag, "_sync"},   o_sync,   64'd0);
    check({tag, "_resync"}, o_resync, 64'd0);
    check({tag, "_bin"},    o_bin,    64'd0);
    check({tag, "_power"},  o_power,  64'd0);
    i_reset = 1'b0;
  endtask

  task automatic finish_group(input string tag);
    flush();
    check({tag, "_output_seen"}, {63'd0, got_first}, 64'd1);
    check({tag, "_latency"}, 64'(first_idx - mark), 64'd3);
    check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic run_group(input string tag, input int mode);
    got_first = 0;
    for (int f = 0; f < 4; f++) send_frame(mode, f);
    finish_group(tag);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  int sq_tab[8] = '{0, 1, 4, 9, 16, 25, 36, 49};

  initial begin
    i_reset      = 1'b1;
    i_clk_enable = 1'b1;
    i_sync       = 1'b0;
    i_result     = '0;
    do_reset("reset_state");

    // constant 3/4 -> 25 on every bin
    resync_cnt = 0;
    for (int k = 0; k < 8; k++) push_exp(38'd25, k);
    run_group("const", 0);
    check("const_no_resync", 64'(resync_cnt), 64'd0);
    do_reset("after_const");

    // re=bin, im=0 -> bin^2
    for (int k = 0; k < 8; k++) push_exp(PW'(sq_tab[k]), k);
    run_group("ramp", 1);
    do_reset("after_ramp");

    // most negative components -> 2^37 without wrap
    for (int k = 0; k < 8; k++) push_exp(38'd137438953472, k);
    run_group("extreme", 2);
    do_reset("after_extreme");

    // sync at bin 5 of frame 2 restarts the group
    resync_cnt = 0;
    got_first  = 0;
    send_frame(3, 0);
    send_frame(3, 1);
    for (int k = 0; k < 5; k++) send(19'd1, 19'd1, k == 0);
    for (int k = 0; k < 8; k++) push_exp(38'd25, k);
    for (int f = 0; f < 4; f++) send_frame(0, f);
    finish_group("resync");
    check("resync_pulses", 64'(resync_cnt), 64'd1);
    do_reset("after_resync");

    // enable toggling every cycle
    gap_mode = 1;
    for (int k = 0; k < 8; k++) push_exp(38'd25, k);
    run_group("gapped", 0);
    gap_mode = 0;
    do_reset("after_gapped");

    // reset at frame 1 bin 3, then a fresh group
    send_frame(4, 0);
    for (int k = 0; k < 3; k++) send(19'd7, 19'd0, k == 0);
    do_reset("mid_reset");
    send(19'd9, 19'd9, 1'b0);
    send(19'd9, 19'd9, 1'b0);
    for (int k = 0; k < 8; k++) push_exp(38'd5, k);
    run_group("post_reset", 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
